// File: rtl/majority_pkg.sv
`default_nettype none
// ============================================================================
// Module      : majority_pkg
// Description : Shared types, popcount helper and parameter legality check
//               for the N-way majority voter.
// Revision    : 1.0 - initial release
// ============================================================================
package majority_pkg;

    localparam int c_MAX_CH = 8;
    localparam int c_POP_W  = 4;

    typedef enum logic [1:0] {
        HEALTHY = 2'd0,
        SUSPECT = 2'd1,
        FAULTED = 2'd2
    } chan_state_t;

    // Channel vectors are zero-extended to c_MAX_CH before counting.
    function automatic logic [c_POP_W-1:0] pop_count(input logic [c_MAX_CH-1:0] v);
        logic [c_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < c_MAX_CH; i++) begin
            n = n + c_POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic bit params_legal(input int n_in, input int fault_limit);
        return (n_in % 2 == 1) && (n_in >= 3) && (n_in <= 7) &&
               (fault_limit >= 1) && (fault_limit <= 15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/majority_chan_monitor.sv
`default_nettype none
// ============================================================================
// Module      : majority_chan_monitor
// Description : Per-channel health FSM, consecutive-disagreement run counter
//               and saturating lifetime mismatch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module majority_chan_monitor
    import majority_pkg::*;
#(
    parameter int FAULT_LIMIT = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vote,
    input  logic             i_quorum,
    input  logic             i_mismatch,
    input  logic             i_mask_clr,
    output logic             o_fault,
    output logic             o_disagree,
    output logic [CNT_W-1:0] o_mis_cnt
);

    localparam int c_RUN_W = $clog2(FAULT_LIMIT + 1);
    localparam logic [c_RUN_W-1:0] c_LIMIT = c_RUN_W'(FAULT_LIMIT);

    chan_state_t        r_state;
    chan_state_t        w_state_nxt;
    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic [c_RUN_W-1:0] w_run_inc;
    logic               r_disagree;
    logic [CNT_W-1:0]   r_mis_cnt;
    logic               w_counted;
    logic               w_dis;
    logic               w_agree;

    // A vote only counts for this channel when quorum exists and it is unmasked.
    assign w_counted = i_vote & i_quorum & (r_state != FAULTED);
    assign w_dis     = w_counted & i_mismatch;
    assign w_agree   = w_counted & ~i_mismatch;
    assign w_run_inc = r_run + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        case (r_state)
            HEALTHY, SUSPECT: begin
                if (w_dis) begin
                    w_run_nxt   = w_run_inc;
                    w_state_nxt = (w_run_inc == c_LIMIT) ? FAULTED : SUSPECT;
                end else if (w_agree) begin
                    w_run_nxt   = '0;
                    w_state_nxt = HEALTHY;
                end
            end
            FAULTED: begin
                w_state_nxt = FAULTED;
            end
            default: begin
                w_state_nxt = HEALTHY;
                w_run_nxt   = '0;
            end
        endcase
        if (i_mask_clr) begin
            w_state_nxt = HEALTHY;
            w_run_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HEALTHY;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // Disagree reflects the last vote; lifetime count survives mask_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disagree <= 1'b0;
            r_mis_cnt  <= '0;
        end else begin
            if (i_vote) begin
                r_disagree <= w_dis;
            end
            if (w_dis && (r_mis_cnt != {CNT_W{1'b1}})) begin
                r_mis_cnt <= r_mis_cnt + 1'b1;
            end
        end
    end

    assign o_fault    = (r_state == FAULTED);
    assign o_disagree = r_disagree;
    assign o_mis_cnt  = r_mis_cnt;

endmodule
`default_nettype wire

// File: rtl/majority_voter.sv
`default_nettype none
// ============================================================================
// Module      : majority_voter
// Description : Registered N-way bitwise majority voter with per-channel
//               fault isolation and quorum detection.
// Revision    : 1.0 - initial release
// ============================================================================
module majority_voter
    import majority_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int WIDTH       = 8,
    parameter int FAULT_LIMIT = 4,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    mask_clr,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [N_IN-1:0]         disagree,
    output logic [N_IN-1:0]         fault,
    output logic [N_IN*CNT_W-1:0]   mis_cnt,
    output logic                    no_quorum
);

    if (!params_legal(N_IN, FAULT_LIMIT)) begin : g_param_check
        $error("majority_voter: N_IN must be odd 3..7 and FAULT_LIMIT 1..15");
    end

    logic [N_IN-1:0]      w_active;
    logic [c_MAX_CH-1:0]  w_active_ext;
    logic [c_POP_W-1:0]   w_act;
    logic                 w_quorum;
    logic [WIDTH-1:0]     w_vote;
    logic [N_IN-1:0]      w_mismatch;
    logic [N_IN-1:0]      w_fault;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_no_quorum;

    assign w_active     = ~w_fault;
    assign w_active_ext = {{(c_MAX_CH-N_IN){1'b0}}, w_active};
    assign w_act        = pop_count(w_active_ext);
    assign w_quorum     = (w_act >= c_POP_W'(2));

    // Ties are only reachable with an even active set; they keep the old bit.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [c_MAX_CH-1:0] w_col;
        logic [c_POP_W-1:0]  w_ones;
        always_comb begin
            w_col = '0;
            for (int i = 0; i < N_IN; i++) begin
                w_col[i] = in_data[i*WIDTH + b] & w_active[i];
            end
        end
        assign w_ones    = pop_count(w_col);
        assign w_vote[b] = ({w_ones, 1'b0} > {1'b0, w_act}) ? 1'b1 :
                           ({w_ones, 1'b0} < {1'b0, w_act}) ? 1'b0 :
                           r_out_data[b];
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        assign w_mismatch[i] = (in_data[i*WIDTH +: WIDTH] != w_vote);

        majority_chan_monitor #(
            .FAULT_LIMIT (FAULT_LIMIT),
            .CNT_W       (CNT_W)
        ) u_mon (
            .clk        (clk),
            .rst        (rst),
            .i_vote     (in_valid),
            .i_quorum   (w_quorum),
            .i_mismatch (w_mismatch[i]),
            .i_mask_clr (mask_clr),
            .o_fault    (w_fault[i]),
            .o_disagree (disagree[i]),
            .o_mis_cnt  (mis_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_no_quorum <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_no_quorum <= ~w_quorum;
                if (w_quorum) begin
                    r_out_data <= w_vote;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign fault     = w_fault;
    assign no_quorum = r_no_quorum;

endmodule
`default_nettype wire
